// File: rtl/arb_pkg.sv
// Shared arbitration types and the round-robin pick function, reused by the
// 4/8/16-way arbiter family.
package arb_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } pick_t;

    // First requester at or after ptr, wrapping; scanned from the far end so
    // the nearest offset is written last and wins.
    function automatic pick_t rr_pick(input logic [N_REQ-1:0] req,
                                      input logic [IDX_W-1:0] ptr);
        pick_t            r;
        logic [IDX_W-1:0] idx;
        r = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = ptr + IDX_W'(k);
            if (req[idx]) begin
                r.found = 1'b1;
                r.idx   = idx;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/Mux8way16.sv
// 8-to-1 selector of 16-bit words; purely combinational, no handshake.
module Mux8way16 (
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic [15:0] C,
    input  logic [15:0] D,
    input  logic [15:0] E,
    input  logic [15:0] F,
    input  logic [15:0] G,
    input  logic [15:0] H,
    input  logic [2:0]  SEL,
    output logic [15:0] OUT
);

    always_comb begin
        case (SEL)
            3'd0:    OUT = A;
            3'd1:    OUT = B;
            3'd2:    OUT = C;
            3'd3:    OUT = D;
            3'd4:    OUT = E;
            3'd5:    OUT = F;
            3'd6:    OUT = G;
            default: OUT = H;
        endcase
    end

endmodule

// File: rtl/arb8way16.sv
// Round-robin arbiter sharing one 16-bit channel among 8 requesters; grant lands one edge after REQ.
// Word is held under VALID until READY; zero-bubble back-to-back grants on transfer.
module arb8way16 #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [7:0]       REQ,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] C,
    input  logic [WIDTH-1:0] D,
    input  logic [WIDTH-1:0] E,
    input  logic [WIDTH-1:0] F,
    input  logic [WIDTH-1:0] G,
    input  logic [WIDTH-1:0] H,
    input  logic             READY,
    output logic [7:0]       GNT,
    output logic [2:0]       SEL,
    output logic [WIDTH-1:0] OUT,
    output logic             VALID,
    output logic [CNT_W-1:0] XFER_CNT
);
    import arb_pkg::*;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] sel_q, sel_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [IDX_W-1:0] ptr_nx;
    pick_t            pick_idle;
    pick_t            pick_busy;

    assign ptr_nx    = sel_q + IDX_W'(1);
    assign pick_idle = rr_pick(REQ, ptr_q);
    // The just-served requester is masked so competitors get their turn first.
    assign pick_busy = rr_pick(REQ & ~(N_REQ'(1) << sel_q), ptr_nx);

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (pick_idle.found) begin
                    sel_d   = pick_idle.idx;
                    gnt_d   = N_REQ'(1) << pick_idle.idx;
                    state_d = BUSY;
                end
            end
            default: begin
                if (READY) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    ptr_d = ptr_nx;
                    if (pick_busy.found) begin
                        sel_d = pick_busy.idx;
                        gnt_d = N_REQ'(1) << pick_busy.idx;
                    end else if (!REQ[sel_q]) begin
                        gnt_d   = '0;
                        state_d = IDLE;
                    end
                    // else: sole remaining requester is re-granted without a bubble
                end else if (!REQ[sel_q]) begin
                    gnt_d   = '0;
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            sel_q   <= '0;
            gnt_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign GNT      = gnt_q;
    assign SEL      = sel_q;
    assign VALID    = (state_q == BUSY);
    assign XFER_CNT = cnt_q;

    Mux8way16 u_mux (
        .A   (A),
        .B   (B),
        .C   (C),
        .D   (D),
        .E   (E),
        .F   (F),
        .G   (G),
        .H   (H),
        .SEL (sel_q),
        .OUT (OUT)
    );

    a_gnt_onehot: assert property (@(posedge CLK) disable iff (RST)
        GNT == (VALID ? (8'd1 << SEL) : 8'd0));

    a_sel_hold: assert property (@(posedge CLK) disable iff (RST)
        (VALID && !READY && REQ[SEL]) |=> $stable(SEL));

endmodule

// File: tb/tb_arb8way16.sv
// Directed-vector bench for arb8way16: reset, round-robin, backpressure,
// withdrawal, pointer wrap and asynchronous reset.
module tb_arb8way16;

    logic        CLK;
    logic        RST;
    logic [7:0]  REQ;
    logic [15:0] A, B, C, D, E, F, G, H;
    logic        READY;
    logic [7:0]  GNT;
    logic [2:0]  SEL;
    logic [15:0] OUT;
    logic        VALID;
    logic [15:0] XFER_CNT;

    int n_vec;
    int n_err;

    arb8way16 #(.WIDTH(16), .CNT_W(16)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .REQ      (REQ),
        .A        (A),
        .B        (B),
        .C        (C),
        .D        (D),
        .E        (E),
        .F        (F),
        .G        (G),
        .H        (H),
        .READY    (READY),
        .GNT      (GNT),
        .SEL      (SEL),
        .OUT      (OUT),
        .VALID    (VALID),
        .XFER_CNT (XFER_CNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        step();
        RST = 1'b0;
    endtask

    task automatic check_grant(input string tag, input logic [2:0] s, input logic [15:0] cnt);
        check({tag, "_valid"}, 32'(VALID), 32'd1);
        check({tag, "_sel"}, 32'(SEL), 32'(s));
        check({tag, "_gnt"}, 32'(GNT), 32'(8'd1 << s));
        check({tag, "_out"}, 32'(OUT), 32'(16'h0001 << s));
        check({tag, "_cnt"}, 32'(XFER_CNT), 32'(cnt));
    endtask

    task automatic check_idle(input string tag, input logic [15:0] cnt);
        check({tag, "_valid"}, 32'(VALID), 32'd0);
        check({tag, "_gnt"}, 32'(GNT), 32'd0);
        check({tag, "_cnt"}, 32'(XFER_CNT), 32'(cnt));
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        RST   = 1'b1;
        REQ   = 8'h00;
        READY = 1'b0;
        A = 16'h0001; B = 16'h0002; C = 16'h0004; D = 16'h0008;
        E = 16'h0010; F = 16'h0020; G = 16'h0040; H = 16'h0080;
        step();
        step();
        RST = 1'b0;

        // Reset state
        check_idle("rst", 16'd0);
        check("rst_sel", 32'(SEL), 32'd0);
        check("rst_out", 32'(OUT), 32'h0001);

        // Single request: grant after one edge, transfer returns to IDLE with PTR=3
        REQ = 8'h04; READY = 1'b1;
        step();
        check_grant("single", 3'd2, 16'd0);
        REQ = 8'h00;
        step();
        check_idle("single_done", 16'd1);
        // PTR=3 means requester 4 beats requester 2
        REQ = 8'h14; READY = 1'b0;
        step();
        check_grant("ptr3", 3'd4, 16'd1);
        REQ = 8'h00;
        step();
        check_idle("ptr3_wd", 16'd1);

        // Round-robin, all requesting, consumer always ready
        do_reset();
        REQ = 8'hFF; READY = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            check_grant($sformatf("rr%0d", k), 3'((k - 1) % 8), 16'(k - 1));
        end
        // Sole requester re-granted back-to-back
        REQ = 8'h04;
        step();
        check_grant("solo1", 3'd2, 16'd10);
        step();
        check_grant("solo2", 3'd2, 16'd11);
        REQ = 8'h00; READY = 1'b0;
        step();
        check_idle("solo_wd", 16'd11);

        // Backpressure
        do_reset();
        REQ = 8'h81; READY = 1'b0;
        step();
        check_grant("bp0", 3'd0, 16'd0);
        for (int k = 0; k < 5; k++) begin
            step();
            check_grant($sformatf("bp_hold%0d", k), 3'd0, 16'd0);
        end
        READY = 1'b1;
        step();
        check_grant("bp_rel", 3'd7, 16'd1);
        // Wrap: transfer on 7 moves PTR to 0
        step();
        check_grant("wrap0", 3'd0, 16'd2);
        step();
        check_grant("wrap7", 3'd7, 16'd3);

        // Withdrawal of a held grant on requester 3
        REQ = 8'h08;
        step();
        check_grant("wd_grant", 3'd3, 16'd4);
        READY = 1'b0;
        step();
        check_grant("wd_hold", 3'd3, 16'd4);
        REQ = 8'h00;
        step();
        check_idle("wd_drop", 16'd4);
        // PTR still 0, so 3 beats 4
        REQ = 8'h18;
        step();
        check_grant("wd_regrant", 3'd3, 16'd4);

        // Asynchronous reset between edges
        #2;
        RST = 1'b1;
        #1;
        check_idle("arst", 16'd0);
        check("arst_sel", 32'(SEL), 32'd0);
        check("arst_out", 32'(OUT), 32'h0001);
        REQ = 8'h00;
        step();
        RST = 1'b0;
        step();
        check_idle("arst_rel", 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
